// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one external 4-bit ALU between two requesters.
// Define ALU_DIV0_TRAP_EN to reject divide (op 0011) with b==0 as an illegal request.
module alu_req_arbiter #(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 4,
  parameter int NUM_OPS = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic rr_ptr, id_q, any_v, gnt, accept, illegal;
  assign any_v  = req0_valid | req1_valid;
  // Contention follows rr_ptr; a lone requester wins regardless of it.
  assign gnt    = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
  assign accept = (state == IDLE) & any_v;
`ifdef ALU_DIV0_TRAP_EN
  assign illegal = ({1'b0, alu_op} >= (OP_W+1)'(NUM_OPS)) | ((alu_op == OP_W'(3)) & (alu_b == '0));
`else
  assign illegal = {1'b0, alu_op} >= (OP_W+1)'(NUM_OPS);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? (any_v ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (resp_ready ? IDLE : RESP);
  end
  // Readys are forced low while reset is asserted even though the FSM already sits in IDLE.
  always_comb begin
    req0_ready = ~rst & accept & ~gnt;
    req1_ready = ~rst & accept & gnt;
    resp_valid = state == RESP;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      id_q        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= ~gnt;
        id_q   <= gnt;
        alu_a  <= gnt ? req1_a : req0_a;
        alu_b  <= gnt ? req1_b : req0_b;
        alu_op <= gnt ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        resp_result <= illegal ? '0 : alu_result;
        resp_flags  <= illegal ? 4'b0 : {alu_carry, alu_overflow, alu_zero, alu_negative};
        resp_err    <= illegal;
      end
    end
  end
  assign resp_id = id_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed checks of grant, latency, backpressure, error and reset behaviour.
module tb_alu_req_arbiter;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, req0_op = 0, req1_op = 0;
  logic [3:0] alu_a, alu_b, alu_op, alu_result, resp_result, resp_flags;
  logic alu_carry, alu_overflow, alu_zero, alu_negative;
  logic resp_valid, resp_ready = 0, resp_id, resp_err, busy;
  int checks = 0, errors = 0;
  int ng, nr;

  alu_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: carry on subtract is the borrow; divide by zero returns 1111 with V,N set.
  logic [4:0] wide;
  always_comb begin
    wide = 5'd0;
    alu_result = alu_a ^ alu_b;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    if (alu_op == 4'd0) begin
      wide = {1'b0, alu_a} + {1'b0, alu_b};
      alu_result = wide[3:0];
      alu_carry = wide[4];
      alu_overflow = (alu_a[3] == alu_b[3]) && (wide[3] != alu_a[3]);
    end else if (alu_op == 4'd1) begin
      wide = {1'b0, alu_a} - {1'b0, alu_b};
      alu_result = wide[3:0];
      alu_carry = wide[4];
      alu_overflow = (alu_a[3] != alu_b[3]) && (wide[3] != alu_a[3]);
    end else if (alu_op == 4'd3) begin
      alu_result = (alu_b == 0) ? 4'hF : alu_a / alu_b;
      alu_overflow = alu_b == 0;
    end
    alu_zero = alu_result == 0;
    alu_negative = alu_result[3];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int n = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin @(posedge clk); #2; n++; end
    chk("accept_wait", n < 20, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
    #1 chk("exec_no_valid", resp_valid, 0);
    chk("exec_busy", busy, 1);
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, id);
  endtask

  task automatic respond();
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    #1 chk("resp_done", resp_valid, 0);
  endtask

  initial begin
    #1 rst = 1;
    #3;
    chk("rst_outs", {req0_ready, req1_ready, alu_a, alu_b, alu_op, resp_valid, resp_id,
                     resp_result, resp_flags, resp_err, busy}, 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;

    send(0, 4'b0111, 4'b1001, 4'b0000);
    chk("add_res", resp_result, 4'b0000);
    chk("add_flags", resp_flags, 4'b1010);
    chk("add_err", resp_err, 0);
    respond();

    send(1, 4'b0011, 4'b0101, 4'b0001);
    chk("sub_res", resp_result, 4'b1110);
    chk("sub_flags", resp_flags, 4'b1001);
    respond();

    // Both requesters held valid: grants must alternate starting with 0.
    req0_a = 1; req0_b = 2; req0_op = 0;
    req1_a = 5; req1_b = 1; req1_op = 0;
    req0_valid = 1; req1_valid = 1; resp_ready = 1;
    ng = 0; nr = 0;
    #1;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      if (req0_ready | req1_ready) begin
        chk("rr_grant", {req1_ready, req0_ready}, ng[0] ? 2'b10 : 2'b01);
        ng++;
      end
      if (resp_valid) begin
        chk("rr_id", resp_id, nr[0]);
        chk("rr_res", resp_result, nr[0] ? 4'd6 : 4'd3);
        nr++;
      end
      @(posedge clk); #2;
      if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
    end
    chk("rr_count", nr, 4);
    resp_ready = 0;

    send(0, 4'd6, 4'd3, 4'd0);
    req1_a = 4'd2; req1_b = 4'd2; req1_op = 4'd1; req1_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {resp_valid, resp_id, resp_result, resp_flags, resp_err}, {1'b1, 1'b0, 4'b1001, 4'b0101, 1'b0});
      chk("bp_ready", {req0_ready, req1_ready, busy}, 3'b001);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    #1 chk("bp_release", {resp_valid, busy, req1_ready}, 3'b001);
    send(1, 4'd2, 4'd2, 4'd1);
    chk("bp_next_res", resp_result, 4'd0);
    chk("bp_next_flags", resp_flags, 4'b0010);
    respond();

    send(0, 4'd5, 4'd3, 4'b1110);
    chk("ill_err", resp_err, 1);
    chk("ill_res", {resp_result, resp_flags}, 8'h00);
    respond();

    send(0, 4'b0110, 4'b0000, 4'b0011);
`ifdef ALU_DIV0_TRAP_EN
    chk("div0_err", resp_err, 1);
    chk("div0_res", {resp_result, resp_flags}, 8'h00);
`else
    chk("div0_err", resp_err, 0);
    chk("div0_res", {resp_result, resp_flags}, {4'b1111, 4'b0101});
`endif
    respond();

    // Abort an operation in EXEC with an asynchronous reset.
    req1_a = 4'd1; req1_b = 4'd1; req1_op = 4'd0; req1_valid = 1;
    #1;
    @(posedge clk); #1;
    req1_valid = 0;
    #2 chk("exec_before_rst", busy, 1);
    rst = 1;
    #1 chk("rst_async", {req0_ready, req1_ready, alu_a, alu_b, alu_op, resp_valid, resp_id,
                         resp_result, resp_flags, resp_err, busy}, 0);
    @(negedge clk) rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("no_stale_resp", resp_valid, 0);
    end
    req0_a = 4'd4; req0_b = 4'd4; req0_op = 4'd0;
    req0_valid = 1; req1_valid = 1;
    #1 chk("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
    req1_valid = 0;
    send(0, 4'd4, 4'd4, 4'd0);
    chk("post_rst_res", resp_result, 4'd8);
    chk("post_rst_flags", resp_flags, 4'b0101);
    respond();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
